// File: rtl/axil_pkg.sv
// Shared types and constants for the single-outstanding AXI-Lite initiator.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_timeout_ctr.sv
// Saturating transaction-age counter; hit is high while enabled and the count equals TIMEOUT.
module axil_timeout_ctr #(
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  import axil_pkg::*;

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + TO_W'(1);
    end
  end

  assign hit = en && (count == LIMIT);

endmodule

// File: rtl/axil_initiator.sv
// Single-outstanding AXI-Lite master: one command in, one bus transaction, one response out.
module axil_initiator #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp
);
  import axil_pkg::*;

  state_t state;
  logic   reported;
  logic   to_hit;
  logic   to_en;
  logic   cmd_fire;
  logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Gating with areset keeps cmd_ready low while the reset is asserted.
  assign cmd_ready = !areset && (state == IDLE) && !rsp_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid && rready;
  assign awprot    = PROT_DEFAULT;
  assign arprot    = PROT_DEFAULT;

  assign to_en = (TIMEOUT != 0) && (state != IDLE);

  axil_timeout_ctr #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_timeout (
    .clk(aclk),
    .rst(areset),
    .clr(cmd_fire),
    .en (to_en),
    .hit(to_hit)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      reported    <= 1'b0;
      awvalid     <= 1'b0;
      awaddr      <= '0;
      wvalid      <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            reported <= 1'b0;
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_ADDR;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (aw_hs) awvalid <= 1'b0;
          if (w_hs)  wvalid  <= 1'b0;
          // A channel is finished if it already dropped or handshakes this cycle.
          if ((aw_hs || !awvalid) && (w_hs || !wvalid)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bready <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A real bus response outranks a timeout landing in the same cycle; once
      // reported, a late bus response is swallowed without a second rsp.
      if (!reported) begin
        if (b_hs) begin
          rsp_valid   <= 1'b1;
          rsp_write   <= 1'b1;
          rsp_rdata   <= '0;
          rsp_resp    <= bresp;
          rsp_timeout <= 1'b0;
          reported    <= 1'b1;
        end else if (r_hs) begin
          rsp_valid   <= 1'b1;
          rsp_write   <= 1'b0;
          rsp_rdata   <= rdata;
          rsp_resp    <= rresp;
          rsp_timeout <= 1'b0;
          reported    <= 1'b1;
        end else if (to_hit) begin
          rsp_valid   <= 1'b1;
          rsp_write   <= (state == WR_ADDR) || (state == WR_RESP);
          rsp_rdata   <= '0;
          rsp_resp    <= RESP_OKAY;
          rsp_timeout <= 1'b1;
          reported    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_initiator.sv
// Bench for axil_initiator: configurable AXI-Lite slave, transaction-level model, directed tests.
module tb_axil_initiator;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 16;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [3:0]        cmd_wstrb = '0;
  logic              rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_timeout;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]        bresp = 2'b00, rresp = 2'b00;
  logic [31:0]       rdata = 32'hBAD0_BAD0;

  always #5 aclk = ~aclk;

  axil_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Slave behaviour knobs, set by the directed tests.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit          b_hold = 0, r_hold = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;

  int aw_wait = 0, w_wait = 0, ar_wait = 0, resp_wait = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0;
  bit s_aw_hs, s_w_hs, s_ar_hs, s_b_hs, s_r_hs;

  initial forever begin
    @(negedge aclk);
    s_aw_hs = awvalid && awready;
    s_w_hs  = wvalid && wready;
    s_ar_hs = arvalid && arready;
    s_b_hs  = bvalid && bready;
    s_r_hs  = rvalid && rready;
    @(posedge aclk);
    #1;
    if (areset) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      rdata = 32'hBAD0_BAD0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; resp_wait = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
    end else begin
      if (s_aw_hs) begin aw_got = 1; aw_wait = 0; end
      if (s_w_hs)  begin w_got = 1;  w_wait = 0;  end
      if (s_ar_hs) begin ar_got = 1; ar_wait = 0; end
      if (s_b_hs)  begin bvalid = 0; aw_got = 0; w_got = 0; resp_wait = 0; end
      if (s_r_hs)  begin rvalid = 0; ar_got = 0; resp_wait = 0; rdata = 32'hBAD0_BAD0; end
      awready = (aw_dly == 0) || (awvalid && aw_wait >= aw_dly);
      if (awvalid && !awready) aw_wait++;
      wready = (w_dly == 0) || (wvalid && w_wait >= w_dly);
      if (wvalid && !wready) w_wait++;
      arready = (ar_dly == 0) || (arvalid && ar_wait >= ar_dly);
      if (arvalid && !arready) ar_wait++;
      if (aw_got && w_got && !bvalid && !b_hold) begin
        if (resp_wait >= b_dly) begin bvalid = 1; bresp = s_bresp; end
        else resp_wait++;
      end
      if (ar_got && !rvalid && !r_hold) begin
        if (resp_wait >= r_dly) begin rvalid = 1; rdata = s_rdata; rresp = s_rresp; end
        else resp_wait++;
      end
    end
  end

  // Transaction-level model: one command in flight, one response per command,
  // response one cycle after the bus response or TIMEOUT+2 cycles after acceptance.
  bit          m_busy = 0, m_write = 0, m_aw_done = 0, m_w_done = 0, m_ar_done = 0;
  bit          m_reported = 0, m_rsp_valid = 0, m_rsp_write = 0, m_rsp_to = 0;
  logic [31:0] m_addr = 0, m_data = 0, m_rsp_rdata = 0;
  logic [3:0]  m_strb = 0;
  logic [1:0]  m_rsp_resp = 0;
  int          m_t_acc = 0;
  int          rsp_count = 0, last_rise = 0, last_aw_hs = 0, last_w_hs = 0, last_bready_rise = 0;
  bit          last_write = 0, last_to = 0, prev_rsp_valid = 0, prev_bready = 0;
  logic [31:0] last_rdata = 0;
  logic [1:0]  last_resp = 0;

  initial forever begin
    @(negedge aclk);
    if (areset) begin
      m_busy = 0; m_rsp_valid = 0; m_reported = 0;
      m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
    end else begin
      chk("cmd_ready", cmd_ready, !m_busy && !m_rsp_valid);
      chk("awvalid", awvalid, m_busy && m_write && !m_aw_done);
      chk("wvalid", wvalid, m_busy && m_write && !m_w_done);
      chk("bready", bready, m_busy && m_write && m_aw_done && m_w_done);
      chk("arvalid", arvalid, m_busy && !m_write && !m_ar_done);
      chk("rready", rready, m_busy && !m_write && m_ar_done);
      chk("prot", {awprot, arprot}, 6'b0);
      if (awvalid) chk("awaddr", awaddr, m_addr);
      if (wvalid) begin
        chk("wdata", wdata, m_data);
        chk("wstrb", wstrb, m_strb);
      end
      if (arvalid) chk("araddr", araddr, m_addr);
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
        chk("rsp_write", rsp_write, m_rsp_write);
        chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
        chk("rsp_resp", rsp_resp, m_rsp_resp);
        chk("rsp_timeout", rsp_timeout, m_rsp_to);
      end

      if (rsp_valid && !prev_rsp_valid) last_rise = cyc;
      if (bready && !prev_bready) last_bready_rise = cyc;
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        last_write = rsp_write; last_rdata = rsp_rdata;
        last_resp = rsp_resp; last_to = rsp_timeout;
      end

      if (m_rsp_valid && rsp_ready) m_rsp_valid = 0;
      if (m_busy) begin
        if (awvalid && awready) begin m_aw_done = 1; last_aw_hs = cyc; end
        if (wvalid && wready)   begin m_w_done = 1;  last_w_hs = cyc;  end
        if (arvalid && arready) m_ar_done = 1;
        if ((bvalid && bready) || (rvalid && rready)) begin
          if (!m_reported) begin
            m_rsp_valid = 1; m_rsp_write = m_write; m_rsp_to = 0;
            m_rsp_rdata = m_write ? 32'h0 : rdata;
            m_rsp_resp  = m_write ? bresp : rresp;
            m_reported  = 1;
          end
          m_busy = 0;
        end else if (!m_reported && cyc == m_t_acc + TIMEOUT + 1) begin
          m_rsp_valid = 1; m_rsp_write = m_write; m_rsp_to = 1;
          m_rsp_rdata = 32'h0; m_rsp_resp = 2'b00;
          m_reported  = 1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        m_busy = 1; m_write = cmd_write; m_addr = cmd_addr;
        m_data = cmd_wdata; m_strb = cmd_wstrb; m_t_acc = cyc;
        m_aw_done = 0; m_w_done = 0; m_ar_done = 0; m_reported = 0;
      end
    end
    prev_rsp_valid = rsp_valid;
    prev_bready = bready;
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output int acc);
    bit ok = 0;
    acc = cyc;
    @(posedge aclk); #1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; acc = cyc; end
    end
    chk("cmd_accept_wait", ok, 1);
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int n0);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge aclk); #1;
      if (rsp_count > n0) ok = 1;
    end
    chk("rsp_arrive_wait", ok, 1);
  endtask

  task automatic wait_idle(output int t);
    bit ok = 0;
    t = cyc;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; t = cyc; end
    end
    chk("idle_wait", ok, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                         rsp_valid, rsp_write, rsp_timeout}, 9'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_resp"}, rsp_resp, 2'b00);
    chk({tag, "_awaddr"}, awaddr, 32'h0);
    chk({tag, "_araddr"}, araddr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_wstrb"}, wstrb, 4'h0);
  endtask

  initial begin
    int acc, t_idle, n0;
    logic [35:0] held;
    bit ok;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_all_zero("reset");
    @(posedge aclk); #1;
    areset = 0;

    // Zero-wait write.
    n0 = rsp_count;
    issue(1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, acc);
    wait_rsp(n0);
    wait_idle(t_idle);
    chk("wr0_aw_cycle", last_aw_hs - acc, 1);
    chk("wr0_w_cycle", last_w_hs - acc, 1);
    chk("wr0_rsp_cycle", last_rise - acc, 3);
    chk("wr0_ready_cycle", t_idle - acc, 4);
    chk("wr0_payload", {last_write, last_to, last_resp, last_rdata}, {1'b1, 1'b0, 2'b00, 32'h0});

    // Write with AW held off three cycles after W.
    aw_dly = 3;
    n0 = rsp_count;
    issue(1, 32'h0000_0010, 32'h0BAD_F00D, 4'h3, acc);
    wait_rsp(n0);
    wait_idle(t_idle);
    repeat (3) @(negedge aclk);
    chk("wr1_w_cycle", last_w_hs - acc, 1);
    chk("wr1_aw_cycle", last_aw_hs - acc, 4);
    chk("wr1_bready_cycle", last_bready_rise - acc, 5);
    chk("wr1_rsp_cycle", last_rise - acc, 6);
    chk("wr1_single_rsp", rsp_count, n0 + 1);
    aw_dly = 0;

    // Read with a delayed SLVERR response.
    r_dly = 5; s_rdata = 32'h1234_5678; s_rresp = 2'b10;
    n0 = rsp_count;
    issue(0, 32'h0000_0004, 32'h0, 4'h0, acc);
    wait_rsp(n0);
    wait_idle(t_idle);
    chk("rd0_rsp_cycle", last_rise - acc, 8);
    chk("rd0_payload", {last_write, last_to, last_resp}, {1'b0, 1'b0, 2'b10});
    chk("rd0_rdata", last_rdata, 32'h1234_5678);

    // Write whose B never comes: timeout response, then late B is swallowed.
    b_hold = 1; s_bresp = 2'b10; r_dly = 0;
    n0 = rsp_count;
    issue(1, 32'h0000_0020, 32'hA5A5_5A5A, 4'hF, acc);
    wait_rsp(n0);
    chk("to_rsp_cycle", last_rise - acc, TIMEOUT + 2);
    chk("to_payload", {last_write, last_to, last_resp, last_rdata}, {1'b1, 1'b1, 2'b00, 32'h0});
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("to_cmd_ready_low", cmd_ready, 1'b0);
    end
    @(posedge aclk); #1;
    b_hold = 0;
    wait_idle(t_idle);
    repeat (3) @(negedge aclk);
    chk("to_single_rsp", rsp_count, n0 + 1);
    chk("to_cmd_ready_back", cmd_ready, 1'b1);
    s_bresp = 2'b00;

    // R arrives exactly when the counter reaches TIMEOUT: bus response wins.
    r_dly = 7; s_rdata = 32'hCAFE_0001; s_rresp = 2'b01;
    n0 = rsp_count;
    issue(0, 32'h0000_0103, 32'h0, 4'h0, acc);
    wait_rsp(n0);
    wait_idle(t_idle);
    chk("edge_rsp_cycle", last_rise - acc, TIMEOUT + 2);
    chk("edge_payload", {last_to, last_resp}, {1'b0, 2'b01});
    chk("edge_rdata", last_rdata, 32'hCAFE_0001);

    // R one cycle later: timeout wins, late data discarded.
    r_dly = 8; s_rdata = 32'hCAFE_0002;
    n0 = rsp_count;
    issue(0, 32'h0000_0200, 32'h0, 4'h0, acc);
    wait_rsp(n0);
    wait_idle(t_idle);
    repeat (2) @(negedge aclk);
    chk("late_payload", {last_write, last_to, last_rdata}, {1'b0, 1'b1, 32'h0});
    chk("late_single_rsp", rsp_count, n0 + 1);
    r_dly = 0;

    // Pending response with rsp_ready low blocks the next command.
    s_bresp = 2'b01; s_rdata = 32'h600D_CAFE; s_rresp = 2'b00;
    n0 = rsp_count;
    @(posedge aclk); #1;
    rsp_ready = 0;
    cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'h1; cmd_valid = 1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge aclk);
      if (cmd_ready) ok = 1;
    end
    chk("blk_accept_wait", ok, 1);
    @(posedge aclk); #1;
    cmd_write = 0; cmd_addr = 32'h34;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge aclk);
      if (rsp_valid) ok = 1;
    end
    chk("blk_rsp_wait", ok, 1);
    held = {rsp_write, rsp_timeout, rsp_resp, rsp_rdata};
    chk("blk_payload", held, {1'b1, 1'b0, 2'b01, 32'h0});
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("blk_cmd_ready_low", cmd_ready, 1'b0);
      chk("blk_rsp_held", rsp_valid, 1'b1);
      chk("blk_payload_stable", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, held);
    end
    @(posedge aclk); #1;
    rsp_ready = 1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge aclk);
      if (cmd_ready) ok = 1;
    end
    chk("blk_second_accept", ok, 1);
    @(posedge aclk); #1;
    cmd_valid = 0;
    wait_rsp(n0 + 1);
    chk("blk_second_rdata", last_rdata, 32'h600D_CAFE);
    chk("blk_rsp_count", rsp_count, n0 + 2);
    s_bresp = 2'b00;

    // Reset asserted while waiting in RD_RESP.
    r_dly = 20;
    issue(0, 32'h0000_0040, 32'h0, 4'h0, acc);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_pre_rready", rready, 1'b1);
    @(posedge aclk); #2;
    areset = 1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge aclk);
    #1;
    areset = 0;

    r_dly = 0; s_rdata = 32'h55AA_55AA; s_rresp = 2'b00;
    wait_idle(t_idle);
    n0 = rsp_count;
    issue(0, 32'h0000_0044, 32'h0, 4'h0, acc);
    wait_rsp(n0);
    chk("post_rst_rdata", last_rdata, 32'h55AA_55AA);
    chk("post_rst_rsp_cycle", last_rise - acc, 3);

    repeat (3) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/axil_initiator.md
Name: axil_initiator

Overview:
- Single-outstanding AXI-Lite master (initiator). Converts a simple valid/ready command stream into one AXI-Lite read or write at a time, and returns the result on a valid/ready response stream.
- Sits in front of CSR slaves so that sequencers, debug bridges and testbenches can drive register reads and writes.
- Includes an optional response timeout. A timeout reports an error to the user early but never breaks AXI-Lite handshake rules.

Parameters:
ADDR_W, 32, AXI-Lite address width (bits)
TIMEOUT, 0, cycles from command acceptance to forced timeout response; 0 = disabled
TO_W, 16, width of timeout counter; TIMEOUT must be < 2**TO_W

Ports:
aclk  input  1  clock, all logic rising-edge
areset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  byte address
cmd_wdata  input  32  write data
cmd_wstrb  input  4  write byte strobes
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_write  output  1  echo of cmd_write
rsp_rdata  output  32  read data; 0 for writes and timeouts
rsp_resp  output  2  bresp/rresp; 2'b00 on timeout
rsp_timeout  output  1  response was forced by timeout
awvalid/awready/awaddr  out/in/out  1/1/ADDR_W  AXI-Lite write address
awprot  output  3  constant 3'b000
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  write data
bvalid/bready/bresp  in/out/in  1/1/2  write response
arvalid/arready/araddr  out/in/out  1/1/ADDR_W  read address
arprot  output  3  constant 3'b000
rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  read data

Behaviour:
- Reset (async assert, sync release): every valid/ready output is 0, including cmd_ready and bready/rready. rsp_* are 0; awaddr/araddr/wdata/wstrb are 0. State is IDLE; the timeout counter is 0.
- All outputs are registered except cmd_ready, which is combinational: cmd_ready = (state==IDLE) && !rsp_valid.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP.
- IDLE, on command handshake:
  - Write: register addr/data/strb, set awvalid=wvalid=1, go to WR_ADDR.
  - Read: set arvalid=1, go to RD_ADDR.
- WR_ADDR:
  - awvalid drops the cycle after the aw handshake; wvalid drops the cycle after the w handshake. The two channels are independent, so either order or the same cycle is legal.
  - When both handshakes are done (including the cycle of the last one), set bready=1 and go to WR_RESP.
- WR_RESP:
  - On bvalid&bready: bready=0, go to IDLE.
  - If no response has been reported yet: rsp_valid=1, rsp_resp=bresp, rsp_write=1, rsp_rdata=0.
- RD_ADDR: on ar handshake, arvalid=0, rready=1, go to RD_RESP.
- RD_RESP: on rvalid&rready, rready=0, go to IDLE. If not yet reported, capture rdata/rresp into rsp_*.
- Valid stability: once asserted, awvalid/wvalid/arvalid and their payloads hold until their handshake. They are never withdrawn, not even on timeout.
- Latency with a zero-wait slave:
  - Command accepted at cycle 0 → aw/w/ar valid at cycle 1.
  - Response accepted at cycle 2 at the earliest.
  - rsp_valid at cycle 3.
  - Next cmd_ready at cycle 4, after rsp is consumed at cycle 3.
- rsp_valid holds, with stable payload, until rsp_ready. rsp_valid and rsp_ready are both sampled together with command acceptance, so there is no back-to-back issue while a response is pending.
- Timeout:
  - The counter clears on command acceptance and increments every cycle while state != IDLE.
  - When it reaches TIMEOUT and the response is not yet reported, rsp_valid=1, rsp_timeout=1, rsp_resp=2'b00, rsp_rdata=0.
  - The bus transaction then continues silently. Its late response is accepted and discarded, and cmd_ready stays 0 until the state returns to IDLE.
  - The counter saturates; it does not wrap.
- Simultaneous bus response and timeout in the same cycle: the bus response wins and rsp_timeout=0.
- Bus response arriving while the prior rsp is still pending: this cannot occur, because commands are only accepted when rsp_valid=0.
- Reset mid-transaction: everything returns to reset values immediately, and the in-flight transaction is abandoned. The system resets slaves on the same reset.
- Address is passed through unmodified; the low 2 bits are not forced.

Decomposition:
- Package axil_pkg holds:
  - the state enum typedef;
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the prot default 3'b000.
- Optional sub-module axil_timeout_ctr: saturating counter with clear/enable, producing a hit pulse. It is tied off when TIMEOUT=0.

Test Plan:
- Write 0x0000_0008, data 0xDEADBEEF, strb 0xF, zero-wait slave → aw and w handshake at cycle 1; rsp at cycle 3 with rsp_write=1, resp=00, rdata=0.
- W accepted 3 cycles before AW (awready delayed) → wvalid drops after its handshake and awvalid holds with stable addr; bready rises only after both handshakes; a single rsp is returned.
- Read 0x4, slave returns rdata 0x1234_5678, rresp=10 with rvalid delayed 5 cycles → rsp_rdata=0x12345678, rsp_resp=10, rsp_timeout=0.
- TIMEOUT=8, slave never asserts bvalid → rsp_timeout=1 at counter=8 and cmd_ready stays 0. Later bvalid is accepted and no second rsp is produced; cmd_ready then returns to 1.
- TIMEOUT=8 with rvalid arriving exactly at count 8 → real response reported, rsp_timeout=0.
- rsp_ready held low for 10 cycles with cmd_valid high → cmd_ready=0 and rsp payload stable throughout. areset pulsed mid-RD_RESP → all outputs 0 in the same cycle.
